// File: rtl/dac_cmd_buffer_if.sv
// Host-bus and serializer-side signals of the DAC command buffer.
// The master modport is the environment: host plus serializer. The slave modport is the buffer.
interface dac_cmd_buffer_if #(
    parameter int NUM_CH = 4
) ();
    localparam int CH_W = $clog2(NUM_CH);

    logic              wen;
    logic [CH_W-1:0]   waddr;
    logic [15:0]       wdata;
    logic [CH_W-1:0]   raddr;
    logic [15:0]       rdata;
    logic [3:0]        addr;
    logic [31:0]       word;
    logic              busy;
    logic              flush;
    logic              trig;
    logic [NUM_CH-1:0] pending;

    modport master (
        output wen, waddr, wdata, raddr, addr, busy, flush,
        input  rdata, word, trig, pending
    );

    modport slave (
        input  wen, waddr, wdata, raddr, addr, busy, flush,
        output rdata, word, trig, pending
    );
endinterface

// File: rtl/dac_cmd_buffer.sv
// Per-channel DAC code store for the LTC2601 daisy chain. It snapshots dirty codes into a shadow bank,
// presents one 32-bit command word per channel to the serializer, and enforces a holdoff between transfers.
module dac_cmd_buffer #(
    parameter int NUM_CH  = 4,
    parameter int HOLDOFF = 16
) (
    input  logic            clkin,
    input  logic            reset,
    dac_cmd_buffer_if.slave bus
);
    localparam int CH_W  = $clog2(NUM_CH);
    localparam int CNT_W = $clog2(HOLDOFF + 1);

    localparam logic [3:0] CMD_WRITE_UPDATE = 4'b0011;
    localparam logic [3:0] CMD_NOP          = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_XFER,
        ST_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [NUM_CH-1:0][15:0] code_q, code_d;
    logic [NUM_CH-1:0][15:0] shadow_q, shadow_d;
    logic [NUM_CH-1:0]       pending_q, pending_d;
    logic [NUM_CH-1:0]       snap_q, snap_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    trig_q, trig_d;
    logic                    busy_prev_q, busy_prev_d;

    logic [NUM_CH-1:0]       wr_mask;
    logic                    busy_fell;
    logic [CH_W-1:0]         word_ch;

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            code_q      <= '0;
            shadow_q    <= '0;
            pending_q   <= '0;
            snap_q      <= '0;
            cnt_q       <= '0;
            trig_q      <= 1'b0;
            busy_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            shadow_q    <= shadow_d;
            pending_q   <= pending_d;
            snap_q      <= snap_d;
            cnt_q       <= cnt_d;
            trig_q      <= trig_d;
            busy_prev_q <= busy_prev_d;
        end
    end

    always_comb begin
        wr_mask = '0;
        if (bus.wen) begin
            wr_mask[bus.waddr] = 1'b1;
        end
    end

    assign busy_prev_d = bus.busy;
    assign busy_fell   = busy_prev_q && !bus.busy;

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        shadow_d  = shadow_q;
        pending_d = pending_q | wr_mask;
        snap_d    = snap_q;
        cnt_d     = cnt_q;

        if (bus.wen) begin
            code_d[bus.waddr] = bus.wdata;
        end

        case (state_q)
            ST_IDLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if ((pending_q != '0) && !bus.busy) begin
                    // A write landing on the snapshot edge stays pending; the shadow takes the old code.
                    shadow_d  = code_q;
                    snap_d    = pending_q;
                    pending_d = wr_mask;
                    state_d   = ST_ARM;
                end
            end
            ST_ARM: begin
                if (bus.busy) begin
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (bus.flush || busy_fell) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                snap_d  = '0;
                cnt_d   = CNT_W'(HOLDOFF - 1);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        trig_d = (state_d == ST_ARM);
    end

    assign word_ch = bus.addr[CH_W-1:0];

    always_comb begin
        bus.word = '0;
        if (bus.addr[3:CH_W] == '0) begin
            bus.word = {8'h00, snap_q[word_ch] ? CMD_WRITE_UPDATE : CMD_NOP, 4'h0, shadow_q[word_ch]};
        end
    end

    assign bus.rdata   = code_q[bus.raddr];
    assign bus.trig    = trig_q;
    assign bus.pending = pending_q;
endmodule

// File: tb/tb_dac_cmd_buffer.sv
// Scenario and randomized bench for dac_cmd_buffer.
// Expected words come from a channel-level model of codes, dirty flags and the last snapshot.
module tb_dac_cmd_buffer;
    localparam int NUM_CH  = 4;
    localparam int HOLDOFF = 16;

    logic clkin = 1'b0;
    logic reset;

    int checks   = 0;
    int failures = 0;

    dac_cmd_buffer_if #(.NUM_CH(NUM_CH)) bus ();

    dac_cmd_buffer #(.NUM_CH(NUM_CH), .HOLDOFF(HOLDOFF)) dut (
        .clkin (clkin),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clkin = ~clkin;

    // Model: host-visible codes, channels dirty since the last snapshot, and what the last snapshot captured.
    logic [15:0] model_code [NUM_CH];
    bit          model_dirty [NUM_CH];
    logic [15:0] sent_code [NUM_CH];
    bit          sent_snap [NUM_CH];

    function automatic logic [3:0] dirty_mask();
        logic [3:0] m;
        m = '0;
        for (int i = 0; i < NUM_CH; i++) m[i] = model_dirty[i];
        return m;
    endfunction

    function automatic logic [31:0] exp_word(input int a);
        if (a >= NUM_CH) return 32'h0000_0000;
        return {8'h00, sent_snap[a] ? 4'h3 : 4'hF, 4'h0, sent_code[a]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            model_code[i]  = 16'h0000;
            model_dirty[i] = 1'b0;
            sent_code[i]   = 16'h0000;
            sent_snap[i]   = 1'b0;
        end
    endtask

    task automatic model_snapshot();
        for (int i = 0; i < NUM_CH; i++) begin
            sent_code[i]   = model_code[i];
            sent_snap[i]   = model_dirty[i];
            model_dirty[i] = 1'b0;
        end
    endtask

    task automatic model_done();
        for (int i = 0; i < NUM_CH; i++) sent_snap[i] = 1'b0;
    endtask

    task automatic tick();
        @(posedge clkin);
        #1;
    endtask

    task automatic do_write(input int c, input logic [15:0] v);
        bus.wen   = 1'b1;
        bus.waddr = 2'(c);
        bus.wdata = v;
        tick();
        bus.wen        = 1'b0;
        model_code[c]  = v;
        model_dirty[c] = 1'b1;
    endtask

    task automatic wait_trig(input int bound, output int n, output bit ok);
        n  = 0;
        ok = bus.trig;
        while (!ok && n < bound) begin
            tick();
            n++;
            ok = bus.trig;
        end
    endtask

    task automatic end_transfer();
        bus.busy = 1'b1;
        tick();
        bus.flush = 1'b1;
        bus.busy  = 1'b0;
        tick();
        bus.flush = 1'b0;
        model_done();
        repeat (HOLDOFF + 2) tick();
    endtask

    task automatic test_reset();
        bus.busy = 1'b1;
        reset    = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.trig !== 1'b0) begin
            failures++;
            $display("FAIL reset_trig: got %b expected 0", bus.trig);
        end
        checks++;
        if (bus.pending !== 4'b0000) begin
            failures++;
            $display("FAIL reset_pending: got %b expected 0000", bus.pending);
        end
        for (int c = 0; c < NUM_CH; c++) begin
            bus.raddr = 2'(c);
            #1;
            checks++;
            if (bus.rdata !== 16'h0000) begin
                failures++;
                $display("FAIL reset_rdata ch%0d: got %h expected 0000", c, bus.rdata);
            end
        end
        bus.addr = 4'd0;
        #1;
        checks++;
        if (bus.word !== 32'h00F0_0000) begin
            failures++;
            $display("FAIL reset_word: got %h expected 00f00000", bus.word);
        end
        tick();
        reset = 1'b0;
        model_reset();
        tick();
    endtask

    // busy is still held from reset, so both writes must merge into one snapshot once busy drops.
    task automatic test_busy_block();
        logic [31:0] exp_w [4];
        int n;
        bit ok;
        do_write(0, 16'h1234);
        do_write(3, 16'hABCD);
        checks++;
        if (bus.pending !== 4'b1001) begin
            failures++;
            $display("FAIL busy_pending: got %b expected 1001", bus.pending);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (bus.trig !== 1'b0) begin
                failures++;
                $display("FAIL busy_block_trig cycle %0d: got %b expected 0", i, bus.trig);
            end
        end
        bus.busy = 1'b0;
        wait_trig(4, n, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL busy_release_trig: got no trig expected trig within 4 cycles");
        end
        model_snapshot();
        checks++;
        if (bus.pending !== 4'b0000) begin
            failures++;
            $display("FAIL busy_snapshot_pending: got %b expected 0000", bus.pending);
        end
        exp_w[0] = 32'h0030_1234;
        exp_w[1] = 32'h00F0_0000;
        exp_w[2] = 32'h00F0_0000;
        exp_w[3] = 32'h0030_ABCD;
        for (int a = 0; a < 4; a++) begin
            bus.addr = 4'(a);
            #1;
            checks++;
            if (bus.word !== exp_w[a]) begin
                failures++;
                $display("FAIL busy_word addr%0d: got %h expected %h", a, bus.word, exp_w[a]);
            end
        end
        bus.busy = 1'b1;
        tick();
        checks++;
        if (bus.trig !== 1'b0) begin
            failures++;
            $display("FAIL busy_xfer_trig: got %b expected 0", bus.trig);
        end
        bus.flush = 1'b1;
        bus.busy  = 1'b0;
        tick();
        bus.flush = 1'b0;
        model_done();
        repeat (HOLDOFF + 2) tick();
    endtask

    task automatic test_single_write();
        logic [31:0] exp_w [4];
        int n;
        bit ok;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        tick();
        do_write(2, 16'h8000);
        checks++;
        if (bus.pending !== 4'b0100) begin
            failures++;
            $display("FAIL single_pending: got %b expected 0100", bus.pending);
        end
        wait_trig(2, n, ok);
        checks++;
        if (!ok || n < 1) begin
            failures++;
            $display("FAIL single_trig_latency: got ok=%0d n=%0d expected trig after 1..2 cycles", ok, n);
        end
        model_snapshot();
        exp_w[0] = 32'h00F0_0000;
        exp_w[1] = 32'h00F0_0000;
        exp_w[2] = 32'h0030_8000;
        exp_w[3] = 32'h00F0_0000;
        for (int a = 0; a < 4; a++) begin
            bus.addr = 4'(a);
            #1;
            checks++;
            if (bus.word !== exp_w[a]) begin
                failures++;
                $display("FAIL single_word addr%0d: got %h expected %h", a, bus.word, exp_w[a]);
            end
        end
        end_transfer();
    endtask

    // The flush edge moves to DONE, then HOLDOFF idle cycles, so trig shows HOLDOFF+1 edges after flush.
    task automatic test_xfer_write_holdoff();
        int n;
        bit ok;
        do_write(2, 16'hC0DE);
        wait_trig(4, n, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL xfer_first_trig: got no trig expected trig");
        end
        model_snapshot();
        bus.busy = 1'b1;
        tick();
        do_write(1, 16'h5555);
        checks++;
        if (bus.pending !== 4'b0010) begin
            failures++;
            $display("FAIL xfer_pending: got %b expected 0010", bus.pending);
        end
        bus.addr = 4'd1;
        #1;
        checks++;
        if (bus.word !== 32'h00F0_0000) begin
            failures++;
            $display("FAIL xfer_shadow_ch1: got %h expected 00f00000", bus.word);
        end
        bus.addr = 4'd2;
        #1;
        checks++;
        if (bus.word !== 32'h0030_C0DE) begin
            failures++;
            $display("FAIL xfer_shadow_ch2: got %h expected 0030c0de", bus.word);
        end
        bus.flush = 1'b1;
        bus.busy  = 1'b0;
        tick();
        bus.flush = 1'b0;
        model_done();
        wait_trig(3 * HOLDOFF, n, ok);
        checks++;
        if (!ok || n != HOLDOFF + 1) begin
            failures++;
            $display("FAIL holdoff_cycles: got ok=%0d n=%0d expected n=%0d", ok, n, HOLDOFF + 1);
        end
        model_snapshot();
        bus.addr = 4'd1;
        #1;
        checks++;
        if (bus.word !== 32'h0030_5555) begin
            failures++;
            $display("FAIL second_word ch1: got %h expected 00305555", bus.word);
        end
        bus.addr = 4'd2;
        #1;
        checks++;
        if (bus.word !== 32'h00F0_C0DE) begin
            failures++;
            $display("FAIL second_word ch2: got %h expected 00f0c0de", bus.word);
        end
        end_transfer();
    endtask

    task automatic test_reset_in_arm();
        int n;
        bit ok;
        do_write(3, 16'h7777);
        wait_trig(4, n, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL arm_trig: got no trig expected trig");
        end
        bus.raddr = 2'd3;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.trig !== 1'b0) begin
            failures++;
            $display("FAIL arm_reset_trig: got %b expected 0", bus.trig);
        end
        checks++;
        if (bus.pending !== 4'b0000) begin
            failures++;
            $display("FAIL arm_reset_pending: got %b expected 0000", bus.pending);
        end
        checks++;
        if (bus.rdata !== 16'h0000) begin
            failures++;
            $display("FAIL arm_reset_rdata: got %h expected 0000", bus.rdata);
        end
        model_reset();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // The second write lands on the same edge that snapshots the first one.
    task automatic test_snapshot_collision();
        int n;
        bit ok;
        bus.busy = 1'b0;
        do_write(0, 16'h1111);
        model_snapshot();
        do_write(1, 16'h2222);
        checks++;
        if (bus.trig !== 1'b1) begin
            failures++;
            $display("FAIL collide_trig: got %b expected 1", bus.trig);
        end
        checks++;
        if (bus.pending !== 4'b0010) begin
            failures++;
            $display("FAIL collide_pending: got %b expected 0010", bus.pending);
        end
        bus.addr = 4'd0;
        #1;
        checks++;
        if (bus.word !== 32'h0030_1111) begin
            failures++;
            $display("FAIL collide_first ch0: got %h expected 00301111", bus.word);
        end
        bus.addr = 4'd1;
        #1;
        checks++;
        if (bus.word !== 32'h00F0_0000) begin
            failures++;
            $display("FAIL collide_first ch1: got %h expected 00f00000", bus.word);
        end
        bus.busy = 1'b1;
        tick();
        bus.flush = 1'b1;
        bus.busy  = 1'b0;
        tick();
        bus.flush = 1'b0;
        model_done();
        wait_trig(3 * HOLDOFF, n, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL collide_second_trig: got no trig expected trig");
        end
        model_snapshot();
        bus.addr = 4'd1;
        #1;
        checks++;
        if (bus.word !== 32'h0030_2222) begin
            failures++;
            $display("FAIL collide_second ch1: got %h expected 00302222", bus.word);
        end
        bus.addr = 4'd0;
        #1;
        checks++;
        if (bus.word !== 32'h00F0_1111) begin
            failures++;
            $display("FAIL collide_second ch0: got %h expected 00f01111", bus.word);
        end
        end_transfer();
    endtask

    // Writes happen only while busy blocks the snapshot, so each transfer's content is fixed by the model.
    task automatic test_random();
        int n;
        int nw;
        int c;
        int a;
        bit ok;
        logic [15:0] v;
        bus.busy = 1'b1;
        for (int round = 0; round < 24; round++) begin
            nw = $urandom_range(1, 4);
            for (int k = 0; k < nw; k++) begin
                c = $urandom_range(0, NUM_CH - 1);
                v = 16'($urandom);
                do_write(c, v);
                repeat ($urandom_range(0, 2)) tick();
            end
            c = $urandom_range(0, NUM_CH - 1);
            bus.raddr = 2'(c);
            #1;
            checks++;
            if (bus.rdata !== model_code[c]) begin
                failures++;
                $display("FAIL rand_rdata r%0d ch%0d: got %h expected %h", round, c, bus.rdata, model_code[c]);
            end
            checks++;
            if (bus.pending !== dirty_mask()) begin
                failures++;
                $display("FAIL rand_pending r%0d: got %b expected %b", round, bus.pending, dirty_mask());
            end
            bus.busy = 1'b0;
            wait_trig(3 * HOLDOFF + 4, n, ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL rand_trig r%0d: got no trig expected trig", round);
                break;
            end
            model_snapshot();
            checks++;
            if (bus.pending !== 4'b0000) begin
                failures++;
                $display("FAIL rand_snap_pending r%0d: got %b expected 0000", round, bus.pending);
            end
            for (int i = 0; i < 5; i++) begin
                a = (i < 4) ? i : $urandom_range(4, 15);
                bus.addr = 4'(a);
                #1;
                checks++;
                if (bus.word !== exp_word(a)) begin
                    failures++;
                    $display("FAIL rand_word r%0d addr%0d: got %h expected %h", round, a, bus.word, exp_word(a));
                end
            end
            if ($urandom_range(0, 1) == 1) begin
                bus.flush = 1'b1;
                tick();
                bus.flush = 1'b0;
                checks++;
                if (bus.trig !== 1'b1) begin
                    failures++;
                    $display("FAIL rand_flush_in_arm r%0d: got %b expected 1", round, bus.trig);
                end
            end
            bus.busy = 1'b1;
            tick();
            checks++;
            if (bus.trig !== 1'b0) begin
                failures++;
                $display("FAIL rand_xfer_trig r%0d: got %b expected 0", round, bus.trig);
            end
            c = $urandom_range(0, NUM_CH - 1);
            if ($urandom_range(0, 1) == 0) begin
                do_write(c, 16'($urandom));
                bus.addr = 4'(c);
                #1;
                checks++;
                if (bus.word !== exp_word(c)) begin
                    failures++;
                    $display("FAIL rand_shadow_hold r%0d ch%0d: got %h expected %h", round, c, bus.word, exp_word(c));
                end
                bus.flush = 1'b1;
                tick();
                bus.flush = 1'b0;
                model_done();
                tick();
            end else begin
                bus.busy = 1'b0;
                tick();
                tick();
                model_done();
                bus.busy = 1'b1;
                checks++;
                if (bus.trig !== 1'b0) begin
                    failures++;
                    $display("FAIL rand_idle_trig r%0d: got %b expected 0", round, bus.trig);
                end
            end
            bus.addr = 4'(c);
            #1;
            checks++;
            if (bus.word !== exp_word(c)) begin
                failures++;
                $display("FAIL rand_done_word r%0d ch%0d: got %h expected %h", round, c, bus.word, exp_word(c));
            end
        end
        bus.busy = 1'b0;
    endtask

    initial begin
        bus.wen   = 1'b0;
        bus.waddr = '0;
        bus.wdata = '0;
        bus.raddr = '0;
        bus.addr  = '0;
        bus.busy  = 1'b0;
        bus.flush = 1'b0;
        reset     = 1'b1;
        model_reset();
        test_reset();
        test_busy_block();
        test_single_write();
        test_xfer_write_holdoff();
        test_reset_in_arm();
        test_snapshot_collision();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got still running expected finished");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
